mult_accum_stage: RTL and testbench
===================================

// Module: mult_accum_stage
// PURPOSE
//  Downstream consumer of the 16x16 Booth/Wallace/CLA multiplier's 32-bit signed product.
//  - Accumulates a programmed number of products into a wide signed accumulator (MAC reduction).
//  - Returns the sum through a valid/ready output port.
//  - Supplies the clocked control the combinational multiplier lacks: start, count, drain.
// PARAMETERS
//  ACC_W   40   accumulator/result width in bits; must be >= 32 (product sign-extended to it)
//  LEN_W   8    width of the product-count field; at most 2**LEN_W-1 products per run
// PORTS
//  clk         in   1      single clock; all state updates on rising edge
//  rst         in   1      synchronous, active-high reset
//  start       in   1      begin a run; sampled only in IDLE
//  len         in   LEN_W  number of products in the run; sampled with start
//  prod_valid  in   1      upstream product valid
//  prod_ready  out  1      stage accepts product this cycle
//  prod        in   32     signed two's-complement product from the multiplier
//  acc_valid   out  1      accumulated result valid
//  acc_ready   in   1      downstream accepts result
//  acc_data    out  ACC_W  signed accumulated result
//  busy        out  1      high in ACCUM or DONE
//  ovf         out  1      sticky: signed overflow (or clamp) occurred during current/last run
// BEHAVIOUR
//  - Reset values: state=IDLE, acc=0, cnt=0, prod_ready=0, acc_valid=0, acc_data=0, busy=0, ovf=0.
//    Reset mid-run discards the run; no partial result is emitted.
//  - States: IDLE, ACCUM, DONE. All outputs are registered or decoded from state only;
//    no combinational path from any input to any output.
//  - IDLE, start=1, len!=0 -> ACCUM; acc<=0, cnt<=len, ovf<=0.
//  - IDLE, start=1, len==0 -> DONE; acc<=0, ovf<=0 (empty run yields 0).
//  - start is ignored outside IDLE.
//  - ACCUM: prod_ready=1.
//    - Handshake (prod_valid & prod_ready): acc <= acc + sext(prod,ACC_W); cnt <= cnt-1.
//    - Handshake with cnt==1 -> DONE.
//    - prod_valid=0: hold all state; bubbles are unbounded.
//  - DONE: acc_valid=1, acc_data=acc, held stable until acc_ready.
//    - acc_valid & acc_ready -> IDLE; acc_valid drops the next cycle.
//    - A start in that same cycle is ignored (state still DONE).
//  - Latency: acc_valid rises 1 cycle after the last product handshake.
//    Throughput: 1 product/cycle in ACCUM.
//  - Overflow is signed ACC_W addition overflow (operand signs equal, result sign differs):
//    sets ovf, which stays set until the next accepted start.
// CONFIGURATION
//  - MULT_ACC_SATURATE_EN defined: on overflow, acc clamps to +2**(ACC_W-1)-1 or -2**(ACC_W-1)
//    per operand sign, and ovf sets.
//  - Not defined: acc wraps modulo 2**ACC_W, and ovf still sets.
// STRUCTURE
//  - Shared package mult_pkg: localparam PROD_W=32; state encoding typedef
//    (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2); ACC_MAX/ACC_MIN constant functions of ACC_W.
//  - One sub-module: acc_sat_add (ACC_W-bit signed add, outputs sum and ovf flag,
//    clamp gated by MULT_ACC_SATURATE_EN). FSM, counter and handshake stay in the top module.
// TESTING
//  1. Basic run: len=3; prods 100,-40,7 back-to-back, acc_ready=1
//     -> acc_data=67, acc_valid 1 cycle after 3rd handshake, ovf=0.
//  2. Bubbles and backpressure: len=2; prods 5,6 with 3 idle cycles between; acc_ready low 4 cycles
//     -> acc_data=11 held stable while acc_valid=1, returns to IDLE after acc_ready.
//  3. Empty run: start with len=0
//     -> DONE next cycle, acc_data=0, prod_ready never asserted.
//  4. Overflow: ACC_W=32; len=2, prods 0x7FFF_FFFF,1
//     -> wrap: acc_data=0x8000_0000, ovf=1; with MULT_ACC_SATURATE_EN: acc_data=0x7FFF_FFFF, ovf=1.
//  5. Reset mid-run: len=4; rst after 2 products
//     -> all outputs 0, state IDLE; a new run len=1, prod=-9 gives acc_data=-9, ovf=0.
//  6. Ignored start: start pulsed during ACCUM with len=7
//     -> original count honoured; end-to-end with the multiplier, 3x(-1234*567) gives -2099034.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier accumulate stage.
//   PROD_W        : width of the signed product delivered by the multiplier
//   mac_state_t   : FSM encoding for mult_accum_stage
//   acc_max/min   : signed clamp limits for an accumulator of a given width
package mult_pkg;

  localparam int PROD_W    = 32;
  localparam int ACC_W_LIM = 128;  // widest accumulator the limit helpers support

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } mac_state_t;

  function automatic logic [ACC_W_LIM-1:0] acc_max(input int w);
    return (ACC_W_LIM'(1) << (w - 1)) - ACC_W_LIM'(1);
  endfunction

  function automatic logic [ACC_W_LIM-1:0] acc_min(input int w);
    return ACC_W_LIM'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/mult_accum_stage_acc_sat_add.sv
// Signed ACC_W-bit adder with overflow flag.
// Optional feature macro: MULT_ACC_SATURATE_EN
//   defined     -> sum clamps to the most positive/negative value on overflow
//   not defined -> sum wraps modulo 2**ACC_W
// Ports:
//   i_a, i_b : signed addends
//   o_sum    : result (wrapped or clamped)
//   o_ovf    : signed overflow of the raw addition
module acc_sat_add
  import mult_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic [ACC_W-1:0] i_a,
  input  logic [ACC_W-1:0] i_b,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_ovf
);

  logic [ACC_W-1:0] w_raw;

  assign w_raw = i_a + i_b;
  // Overflow only possible when both operands share a sign and the result flips it.
  assign o_ovf = (i_a[ACC_W-1] == i_b[ACC_W-1]) && (w_raw[ACC_W-1] != i_a[ACC_W-1]);

`ifdef MULT_ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(acc_max(ACC_W));
  localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(acc_min(ACC_W));

  // Operand sign picks the clamp direction: negative operands can only underflow.
  assign o_sum = o_ovf ? (i_a[ACC_W-1] ? SAT_MIN : SAT_MAX) : w_raw;
`else
  assign o_sum = w_raw;
`endif

endmodule

// File: rtl/mult_accum_stage.sv
// Accumulates a programmed number of 32-bit signed products and returns the
// sum on a valid/ready port. Overflow behaviour follows MULT_ACC_SATURATE_EN
// (see acc_sat_add): clamp when defined, wrap otherwise; ovf sets either way.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   start, len                    : launch a run of len products (IDLE only)
//   prod_valid/prod_ready/prod    : product input handshake
//   acc_valid/acc_ready/acc_data  : result output handshake
//   busy                          : run in progress or result pending
//   ovf                           : sticky overflow for current/last run
//
// state | meaning
// IDLE  | waiting for start
// ACCUM | accepting products, cnt = products still to take
// DONE  | result presented, waiting for acc_ready
module mult_accum_stage
  import mult_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_data,
  output logic              busy,
  output logic              ovf
);

  mac_state_t       r_state;
  mac_state_t       w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [LEN_W-1:0] r_cnt;
  logic             r_ovf;

  logic [ACC_W-1:0] w_prod_ext;
  logic [ACC_W-1:0] w_sum;
  logic             w_add_ovf;
  logic             w_prod_hs;

  assign w_prod_ext = ACC_W'($signed(prod));
  assign w_prod_hs  = prod_valid && (r_state == ACCUM);

  acc_sat_add #(.ACC_W(ACC_W)) u_add (
    .i_a   (r_acc),
    .i_b   (w_prod_ext),
    .o_sum (w_sum),
    .o_ovf (w_add_ovf)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = (len == '0) ? DONE : ACCUM;
      ACCUM:   if (w_prod_hs && (r_cnt == LEN_W'(1))) w_state_nxt = DONE;
      DONE:    if (acc_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && start) begin
        r_acc <= '0;
        r_cnt <= len;
        r_ovf <= 1'b0;
      end else if (w_prod_hs) begin
        r_acc <= w_sum;
        r_cnt <= r_cnt - LEN_W'(1);
        if (w_add_ovf) r_ovf <= 1'b1;
      end
    end
  end

  // All outputs come from registers or state decode; no input-to-output path.
  assign prod_ready = (r_state == ACCUM);
  assign acc_valid  = (r_state == DONE);
  assign busy       = (r_state != IDLE);
  assign acc_data   = r_acc;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_mult_accum_stage.sv
module tb_mult_accum_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        prod_valid;
  logic [31:0] prod;
  logic        acc_ready;

  logic        prod_ready, acc_valid, busy, ovf;
  logic [39:0] acc_data;
  logic        prod_ready32, acc_valid32, busy32, ovf32;
  logic [31:0] acc_data32;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  mult_accum_stage #(.ACC_W(40), .LEN_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .prod(prod),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
    .busy(busy), .ovf(ovf)
  );

  mult_accum_stage #(.ACC_W(32), .LEN_W(8)) u_dut32 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .prod_valid(prod_valid), .prod_ready(prod_ready32), .prod(prod),
    .acc_valid(acc_valid32), .acc_ready(acc_ready), .acc_data(acc_data32),
    .busy(busy32), .ovf(ovf32)
  );

  // inputs change and outputs are sampled on the falling edge
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; len = '0; prod_valid = 1'b0; prod = '0; acc_ready = 1'b0;
    cyc(); cyc();
    chk_cnt++;
    if ({prod_ready, acc_valid, busy, ovf, acc_data} !== 44'd0)
      $display("FAIL reset_outputs got rdy=%0b vld=%0b busy=%0b ovf=%0b data=%h exp all 0",
               prod_ready, acc_valid, busy, ovf, acc_data);
    else pass_cnt++;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    logic signed [39:0] e;
    acc_ready = 1'b1;
    start = 1'b1; len = 8'd3;
    cyc();
    start = 1'b0;
    chk_cnt++;
    if (prod_ready !== 1'b1 || busy !== 1'b1)
      $display("FAIL basic_accum_entry got rdy=%0b busy=%0b exp 1 1", prod_ready, busy);
    else pass_cnt++;
    prod_valid = 1'b1; prod = 32'd100;  cyc();
    prod = -32'sd40;                    cyc();
    prod = 32'd7;                       cyc();
    prod_valid = 1'b0;
    e = 67;
    chk_cnt++;
    if (acc_valid !== 1'b1 || acc_data !== e || ovf !== 1'b0 || prod_ready !== 1'b0)
      $display("FAIL basic_result got vld=%0b data=%0d ovf=%0b rdy=%0b exp 1 67 0 0",
               acc_valid, $signed(acc_data), ovf, prod_ready);
    else pass_cnt++;
    cyc();
    chk_cnt++;
    if (acc_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_return_idle got vld=%0b busy=%0b exp 0 0", acc_valid, busy);
    else pass_cnt++;
  endtask

  task automatic test_bubbles_backpressure();
    acc_ready = 1'b0;
    start = 1'b1; len = 8'd2;
    cyc();
    start = 1'b0;
    prod_valid = 1'b1; prod = 32'd5; cyc();
    prod_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_cnt++;
      if (prod_ready !== 1'b1 || acc_data !== 40'd5 || acc_valid !== 1'b0)
        $display("FAIL bubble_hold[%0d] got rdy=%0b data=%0d vld=%0b exp 1 5 0",
                 i, prod_ready, acc_data, acc_valid);
      else pass_cnt++;
    end
    prod_valid = 1'b1; prod = 32'd6; cyc();
    prod_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if (acc_valid !== 1'b1 || acc_data !== 40'd11)
        $display("FAIL backpressure_hold[%0d] got vld=%0b data=%0d exp 1 11", i, acc_valid, acc_data);
      else pass_cnt++;
      cyc();
    end
    // start in the same cycle as the result handshake must be ignored
    acc_ready = 1'b1; start = 1'b1; len = 8'd5;
    cyc();
    start = 1'b0;
    chk_cnt++;
    if (busy !== 1'b0 || acc_valid !== 1'b0 || prod_ready !== 1'b0)
      $display("FAIL done_start_ignored got busy=%0b vld=%0b rdy=%0b exp 0 0 0", busy, acc_valid, prod_ready);
    else pass_cnt++;
  endtask

  task automatic test_empty_run();
    acc_ready = 1'b0;
    start = 1'b1; len = 8'd0;
    cyc();
    start = 1'b0;
    chk_cnt++;
    if (acc_valid !== 1'b1 || acc_data !== 40'd0 || prod_ready !== 1'b0)
      $display("FAIL empty_run got vld=%0b data=%0d rdy=%0b exp 1 0 0", acc_valid, acc_data, prod_ready);
    else pass_cnt++;
    acc_ready = 1'b1;
    cyc();
    chk_cnt++;
    if (busy !== 1'b0)
      $display("FAIL empty_return_idle got busy=%0b exp 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [31:0] e32;
`ifdef MULT_ACC_SATURATE_EN
    e32 = 32'h7FFF_FFFF;
`else
    e32 = 32'h8000_0000;
`endif
    acc_ready = 1'b0;
    start = 1'b1; len = 8'd2;
    cyc();
    start = 1'b0;
    prod_valid = 1'b1; prod = 32'h7FFF_FFFF; cyc();
    prod = 32'd1;                            cyc();
    prod_valid = 1'b0;
    chk_cnt++;
    if (acc_valid32 !== 1'b1 || acc_data32 !== e32 || ovf32 !== 1'b1)
      $display("FAIL ovf_acc32 got vld=%0b data=%h ovf=%0b exp 1 %h 1", acc_valid32, acc_data32, ovf32, e32);
    else pass_cnt++;
    chk_cnt++;
    if (acc_data !== 40'h00_8000_0000 || ovf !== 1'b0)
      $display("FAIL ovf_acc40_no_ovf got data=%h ovf=%0b exp 0080000000 0", acc_data, ovf);
    else pass_cnt++;
    acc_ready = 1'b1;
    cyc();
    chk_cnt++;
    if (ovf32 !== 1'b1 || busy32 !== 1'b0)
      $display("FAIL ovf_sticky_idle got ovf=%0b busy=%0b exp 1 0", ovf32, busy32);
    else pass_cnt++;
  endtask

  task automatic test_reset_midrun();
    logic signed [39:0] e;
    acc_ready = 1'b1;
    start = 1'b1; len = 8'd4;
    cyc();
    start = 1'b0;
    prod_valid = 1'b1; prod = 32'd1; cyc();
    prod = 32'd2;                    cyc();
    prod_valid = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_cnt++;
    if ({prod_ready, acc_valid, busy, ovf, acc_data} !== 44'd0 || ovf32 !== 1'b0)
      $display("FAIL midrun_reset got rdy=%0b vld=%0b busy=%0b ovf=%0b data=%h ovf32=%0b exp all 0",
               prod_ready, acc_valid, busy, ovf, acc_data, ovf32);
    else pass_cnt++;
    start = 1'b1; len = 8'd1;
    cyc();
    start = 1'b0;
    prod_valid = 1'b1; prod = -32'sd9; cyc();
    prod_valid = 1'b0;
    e = -9;
    chk_cnt++;
    if (acc_valid !== 1'b1 || acc_data !== e || ovf !== 1'b0)
      $display("FAIL after_reset_run got vld=%0b data=%0d ovf=%0b exp 1 -9 0", acc_valid, $signed(acc_data), ovf);
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_ignored_start();
    logic signed [39:0] e;
    int p;
    p = -1234 * 567;
    acc_ready = 1'b1;
    start = 1'b1; len = 8'd3;
    cyc();
    start = 1'b0;
    prod_valid = 1'b1; prod = p; cyc();
    start = 1'b1; len = 8'd7; cyc();
    start = 1'b0;              cyc();
    prod_valid = 1'b0;
    e = -2099034;
    chk_cnt++;
    if (acc_valid !== 1'b1 || acc_data !== e)
      $display("FAIL ignored_start_result got vld=%0b data=%0d exp 1 -2099034", acc_valid, $signed(acc_data));
    else pass_cnt++;
    cyc();
    chk_cnt++;
    if (busy !== 1'b0)
      $display("FAIL ignored_start_idle got busy=%0b exp 0", busy);
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_bubbles_backpressure();
    test_empty_run();
    test_overflow();
    test_reset_midrun();
    test_ignored_start();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
